// File: rtl/conv_pkg.sv
// Shared defaults, FSM state encoding and the activation quantiser for the conv psum writer.
package conv_pkg;
   localparam int ACC_W      = 24;
   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 132;
   localparam int ADDR_W     = 8;

   typedef enum logic [2:0] {IDLE, RD, WR, ACK, HOLD} state_t;

   // ReLU, arithmetic right shift, then clamp into the unsigned activation range.
   function automatic logic [DATA_WIDTH-1:0] quant_relu(input logic signed [ACC_W-1:0] sum,
                                                        input logic [4:0]              shift);
      logic signed [ACC_W-1:0] q;
      q = sum >>> shift;
      if (sum[ACC_W-1]) return '0;
      if (|q[ACC_W-1:DATA_WIDTH]) return '1;
      return q[DATA_WIDTH-1:0];
   endfunction
endpackage

// File: rtl/psum_ram.sv
// Partial-sum store: DEPTH x ACC_W, one synchronous read port and one write port.
module psum_ram #(
   parameter int ACC_W  = conv_pkg::ACC_W,
   parameter int DEPTH  = conv_pkg::DEPTH,
   parameter int ADDR_W = conv_pkg::ADDR_W
) (
   input  logic                     clk,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic signed [ACC_W-1:0]  rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [ACC_W-1:0]  wr_data
);
   logic signed [ACC_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/conv_psum_writer.sv
// Commits conv beats into the partial-sum store and, on the last channel, an 8-bit activation.
// Build option: define CONV_PSUM_SAT_EN to saturate the accumulation instead of wrapping.
module conv_psum_writer
   import conv_pkg::*;
#(
   parameter int ACC_W      = conv_pkg::ACC_W,
   parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
   parameter int DEPTH      = conv_pkg::DEPTH,
   parameter int ADDR_W     = conv_pkg::ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [ACC_W-1:0]      pixel,
   input  logic                  first_chan,
   input  logic                  last_chan,
   input  logic [4:0]            shift,
   output logic                  save_done,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  addr_err,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

   state_t state, nxt;

   logic [ADDR_W-1:0]       addr_p0;
   logic signed [ACC_W-1:0] pixel_p0;
   logic                    first_p0, last_p0;
   logic [4:0]              shift_p0;
   logic                    in_range_p0;
   logic signed [ACC_W-1:0] psum_p1, sum_p1;
   logic                    ram_rd, ram_wr;
   logic [DATA_WIDTH-1:0]   act [DEPTH];

   function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
`ifdef CONV_PSUM_SAT_EN
      logic signed [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
`else
      return a + b;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt        = state;
      save_done  = 1'b0;
      frame_done = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: if (valid) nxt = RD;
         RD:   nxt = WR;
         WR:   nxt = ACK;
         ACK: begin
            save_done  = 1'b1;
            frame_done = last_p0 && (addr_p0 == LAST_A);
            nxt        = HOLD;
         end
         HOLD: if (!valid || (addr != addr_p0)) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // p0: beat captured in IDLE; later input changes are ignored until the next IDLE
   always_ff @(posedge clk) begin
      if (state == IDLE && valid) begin
         addr_p0  <= addr;
         pixel_p0 <= pixel;
         first_p0 <= first_chan;
         last_p0  <= last_chan;
         shift_p0 <= shift;
      end
   end

   assign in_range_p0 = (addr_p0 < DEPTH_A);
   assign ram_rd      = (state == RD) && in_range_p0;
   // A reset landing in WR drops the beat, so the commit is suppressed too.
   assign ram_wr      = (state == WR) && in_range_p0 && !rst;

   // p1: stored partial sum available in WR
   assign sum_p1 = first_p0 ? pixel_p0 : acc_add(psum_p1, pixel_p0);

   psum_ram #(.ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_psum_ram (
      .clk     (clk),
      .rd_en   (ram_rd),
      .rd_addr (addr_p0),
      .rd_data (psum_p1),
      .wr_en   (ram_wr),
      .wr_addr (addr_p0),
      .wr_data (sum_p1)
   );

   always_ff @(posedge clk) begin
      if (ram_wr && last_p0) act[addr_p0] <= quant_relu(sum_p1, shift_p0);
   end

   always_ff @(posedge clk) begin
      if (rst)                               addr_err <= 1'b0;
      else if (state == WR && !in_range_p0)  addr_err <= 1'b1;
   end

   // Same-cycle write to the read address returns the pre-write activation.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= (rd_addr < DEPTH_A) ? act[rd_addr] : '0;
   end
endmodule

// File: tb/tb_conv_psum_writer.sv
// Scoreboarded bench for conv_psum_writer: directed cases plus randomized beats against a reference model.
module tb_conv_psum_writer;
   localparam int N = 132;

   logic       clk = 1'b0;
   logic       rst, valid, first_chan, last_chan, rd_en;
   logic [7:0] addr, rd_addr;
   logic [23:0] pixel;
   logic [4:0] shift;
   logic       save_done, busy, frame_done, addr_err;
   logic [7:0] rd_data;

   conv_psum_writer dut (
      .clk        (clk),
      .rst        (rst),
      .valid      (valid),
      .addr       (addr),
      .pixel      (pixel),
      .first_chan (first_chan),
      .last_chan  (last_chan),
      .shift      (shift),
      .save_done  (save_done),
      .busy       (busy),
      .frame_done (frame_done),
      .addr_err   (addr_err),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit frame;
      bit aerr;
      int ack_cyc;
   } exp_t;

   exp_t   expq[$];
   int     rdq[$];
   exp_t   me;
   int     errors = 0;
   int     checks = 0;
   int     cyc = 0;
   int     last_rd = 0;
   bit     rd_was = 0;
   bit     chained = 0;
   bit     aerr_m = 0;
   longint psum_m[N];
   bit     psum_k[N];
   int     act_m[N];
   bit     act_k[N];

   task automatic chk(input string nm, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   // Reference arithmetic on plain integers.
   function automatic longint acc(input longint a, input longint b);
      longint s;
      s = a + b;
`ifdef CONV_PSUM_SAT_EN
      if (s > 8388607)  s = 8388607;
      if (s < -8388608) s = -8388608;
`else
      s = ((s % 16777216) + 16777216) % 16777216;
      if (s >= 8388608) s = s - 16777216;
`endif
      return s;
   endfunction

   function automatic int quant(input longint s, input int sh);
      longint v;
      if (s < 0) return 0;
      v = s / (longint'(1) << sh);
      return (v > 255) ? 255 : int'(v);
   endfunction

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rd_was <= rd_en && !rst;
   end

   // Monitor: pops expectations whenever the DUT acknowledges or returns read data.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_was) begin
            if (rdq.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_unexpected: got read data %0d expected no read", rd_data);
            end else begin
               last_rd = rdq.pop_front();
               chk("rd_data", longint'(rd_data), longint'(last_rd));
            end
         end else begin
            chk("rd_hold", longint'(rd_data), longint'(last_rd));
         end
         if (save_done) begin
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_save_done: got save_done=1 expected 0 at cycle %0d", cyc);
            end else begin
               me = expq.pop_front();
               chk("frame_done", longint'(frame_done), longint'(me.frame));
               chk("addr_err", longint'(addr_err), longint'(me.aerr));
               chk("ack_cycle", longint'(cyc), longint'(me.ack_cyc));
               chk("busy_in_ack", longint'(busy), 1);
            end
         end else if (frame_done) begin
            checks++; errors++;
            $display("FAIL frame_no_ack: got frame_done=1 expected 0 at cycle %0d", cyc);
         end
      end
   end

   task automatic send(input int a, input longint px, input bit f, input bit l, input int sh,
                       input int hold, input bit chain, input bit rd_wr);
      exp_t e;
      int   n, extra;
      bit   got;
      extra = chained ? 1 : 0;
      @(negedge clk);
      n = cyc;
      valid = 1'b1; addr = 8'(a); pixel = 24'(px);
      first_chan = f; last_chan = l; shift = 5'(sh);
      if (rd_wr) rdq.push_back(act_m[a]);
      if (a < N) begin
         psum_m[a] = f ? px : acc(psum_m[a], px);
         psum_k[a] = 1'b1;
         if (l) begin
            act_m[a] = quant(psum_m[a], sh);
            act_k[a] = 1'b1;
         end
      end else begin
         aerr_m = 1'b1;
      end
      e.frame   = l && (a == N - 1);
      e.aerr    = aerr_m;
      e.ack_cyc = n + 3 + extra;
      expq.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (rd_wr && i == 2 + extra) rd_en = 1'b0;
         if (rd_wr && i == 1 + extra) begin
            rd_en = 1'b1; rd_addr = 8'(a);
         end
         if (save_done) got = 1'b1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL ack_timeout: got no save_done expected one for addr %0d", a);
      end
      repeat (hold) @(negedge clk);
      chained = chain;
      if (!chain) begin
         valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic rd(input int a);
      @(negedge clk);
      rd_en = 1'b1; rd_addr = 8'(a);
      rdq.push_back((a < N) ? act_m[a] : 0);
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      int     a, ra, sh;
      longint px;
      bit     f, l, rw;
      rst = 1'b1; valid = 1'b0; addr = '0; pixel = '0; first_chan = 1'b0;
      last_chan = 1'b0; shift = '0; rd_en = 1'b0; rd_addr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_save_done", longint'(save_done), 0);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_frame_done", longint'(frame_done), 0);
      chk("reset_addr_err", longint'(addr_err), 0);
      chk("reset_rd_data", longint'(rd_data), 0);

      send(5, 300, 1, 1, 1, 0, 0, 0);            rd(5);
      send(0, 100, 1, 0, 0, 0, 0, 0);
      send(0, -40, 0, 0, 0, 0, 0, 0);
      send(0, 20, 0, 1, 0, 0, 0, 0);              rd(0);
      send(0, 100, 1, 0, 0, 0, 0, 0);
      send(0, -320, 0, 0, 0, 0, 0, 0);
      send(0, 20, 0, 1, 0, 0, 0, 0);              rd(0);
      send(1, 64'h7FFFF0, 1, 0, 0, 0, 0, 0);
      send(1, 64'h100, 0, 1, 0, 0, 0, 0);         rd(1);
      send(2, 1000, 1, 1, 0, 0, 0, 0);            rd(2);

      // valid held with the same address, then a new address while still valid
      send(3, 10, 1, 1, 0, 10, 1, 0);
      send(4, 7, 1, 1, 0, 0, 0, 0);
      send(3, 5, 0, 1, 0, 0, 0, 0);               rd(3); rd(4);

      send(140, 55, 1, 1, 0, 0, 0, 0);            rd(140); rd(5);
      send(131, 77, 1, 1, 0, 0, 0, 0);            rd(131);
      rd(5);

      // reset while the beat is in WR: dropped, no ack, no store change
      @(negedge clk);
      valid = 1'b1; addr = 8'd5; pixel = 24'd999; first_chan = 1'b1; last_chan = 1'b1; shift = 5'd0;
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1; valid = 1'b0; last_rd = 0; aerr_m = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("wrrst_save_done", longint'(save_done), 0);
      chk("wrrst_busy", longint'(busy), 0);
      chk("wrrst_frame_done", longint'(frame_done), 0);
      chk("wrrst_addr_err", longint'(addr_err), 0);
      chk("wrrst_rd_data", longint'(rd_data), 0);
      repeat (4) @(negedge clk);
      rd(5);
      send(6, 42, 1, 1, 0, 0, 0, 0);              rd(6);

      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 19) == 0) a = int'($urandom_range(N, 255));
         else                            a = int'($urandom_range(0, N - 1));
         if ($urandom_range(0, 7) == 0) px = longint'($urandom_range(0, 16777215)) - 8388608;
         else                           px = longint'($urandom_range(0, 4000)) - 2000;
         if (a >= N) f = 1'b1;
         else        f = !psum_k[a] || ($urandom_range(0, 3) == 0);
         l  = 1'($urandom_range(0, 1));
         sh = int'($urandom_range(0, 12));
         rw = 1'b0;
         if (a < N) rw = act_k[a] && ($urandom_range(0, 3) == 0);
         send(a, px, f, l, sh, 0, 0, rw);
         if ($urandom_range(0, 2) == 0) begin
            ra = int'($urandom_range(0, N - 1));
            if (act_k[ra]) rd(ra);
            else           rd(200);
         end
      end

      repeat (5) @(negedge clk);
      chk("pending_acks", longint'(expq.size()), 0);
      chk("pending_reads", longint'(rdq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/conv_psum_writer.md
# conv_psum_writer

Receiver end of the conv pixel handshake: accepts each `valid`/`addr`/`out_pixel` beat from the conv engine, accumulates it into a per-pixel partial-sum store, and returns a one-cycle `save_done` pulse once the beat is committed. On the last input channel it also writes a ReLU'd, shifted, saturated 8-bit activation into an output byte store. The next layer reads that store through a registered read port. The block sits between the conv engine and the next layer's input buffer.

## Interface
Parameters:
- `ACC_W`, 24, width of the incoming conv pixel and of the partial sums (signed)
- `DATA_WIDTH`, 8, output activation width (unsigned)
- `DEPTH`, 132, number of output pixels (12×11)
- `ADDR_W`, 8, pixel address width

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `valid`  in  1  conv beat present; held with `addr`/`pixel` until `save_done`
- `addr`  in  ADDR_W  linear output pixel index (row*out_w+col)
- `pixel`  in  ACC_W  signed conv result
- `first_chan`  in  1  overwrite the sum instead of accumulating; sampled with the beat
- `last_chan`  in  1  also produce the 8-bit activation; sampled with the beat
- `shift`  in  5  right-shift applied before 8-bit quantisation
- `save_done`  out  1  one-cycle commit acknowledge to the conv engine
- `busy`  out  1  high while a beat is in flight
- `frame_done`  out  1  one-cycle pulse after a last_chan commit to addr DEPTH-1
- `addr_err`  out  1  sticky; set when a beat has addr ≥ DEPTH; cleared only by `rst`
- `rd_en`  in  1  activation read strobe
- `rd_addr`  in  ADDR_W  activation read address
- `rd_data`  out  DATA_WIDTH  registered activation read data

## Operation
- FSM states: IDLE, RD, WR, ACK, HOLD.
- IDLE:
  - When `valid`=1, latch `addr`, `pixel`, `first_chan`, `last_chan` and `shift`, then go to RD.
  - While `valid`=0, stay in IDLE.
- RD: read `psum[addr]` into an operand register, then go to WR.
- WR:
  - Compute `sum = first_chan ? pixel : psum + pixel` and write `psum[addr] = sum`.
  - If `last_chan`, write `act[addr] = min(255, max(0, sum) >>> shift)`.
  - Go to ACK.
- ACK: `save_done`=1 for this one cycle. Pulse `frame_done` in the same cycle if the beat was last_chan with addr==DEPTH-1. Go to HOLD.
- HOLD: return to IDLE when `valid`=0, or when `addr` differs from the latched address. A beat that is still held is never committed twice.
- If addr ≥ DEPTH, no store is written, `addr_err` is set, and the ACK is still given so the conv engine never stalls.
- Read port: `rd_data` ← `act[rd_addr]` one cycle after `rd_en`. It holds its value when `rd_en`=0, and returns 0 for rd_addr ≥ DEPTH.
- A read and a write to the same address in the same cycle return the old value.

## Timing
- Beat sampled in IDLE at edge t → RD t+1, WR t+2, `save_done` high during cycle t+3, HOLD from t+4.
- Minimum beat period is 5 cycles.
- `busy` is high in RD, WR, ACK and HOLD.
- `rst` forces IDLE and clears `save_done`, `busy`, `frame_done`, `addr_err` and `rd_data` to 0.
  - The psum and act stores are not cleared.
  - A beat in progress is dropped without ACK; the conv engine must be reset at the same time.
- Inputs that change in RD, WR or ACK are ignored; only the latched copies are used.

## Configuration
- `CONV_PSUM_SAT_EN` defined:
  - The accumulation `psum + pixel` saturates to [−2^23, 2^23−1].
- `CONV_PSUM_SAT_EN` undefined:
  - The accumulation wraps modulo 2^24, two's complement.
  - Activation quantisation still clamps to [0,255].

## Structure
- Shared package `conv_pkg` holds:
  - `ACC_W`, `DATA_WIDTH`, `DEPTH` and `ADDR_W` defaults
  - the FSM state enum
  - the `quant_relu(sum, shift)` function
- One sub-module: `psum_ram`, a DEPTH×ACC_W synchronous-read, single-write store.
  - The act store is a plain register array in the top level.

## Test plan
- Single channel: beat addr=5, pixel=+300, first=1, last=1, shift=1 → `save_done` at t+3; rd addr 5 → 150.
- Three-channel accumulation at addr 0: +100 (first), −40, +20 (last), shift=0 → psum 80, act 80. Repeat with a −200 total → act 0.
- Saturation:
  - With `CONV_PSUM_SAT_EN`: psum 0x7FFFF0 plus +0x100 → 0x7FFFFF.
  - Without it: the same input wraps negative, so act=0.
  - Independently, sum 1000 with shift 0 → act 255.
- Handshake hold: keep `valid` high with the same addr for 10 cycles after ACK → exactly one `save_done` and one accumulation. Changing addr while `valid` stays high → second commit.
- Error and frame:
  - Beat at addr 140 → `addr_err`=1, ACK given, no store change.
  - last_chan beat at addr 131 → `frame_done` pulses together with `save_done`.
- Reset in WR (`rst` for 1 cycle) → no `save_done`; state IDLE; all outputs 0. The next beat proceeds normally.
